// File: rtl/demux_stream_1_to_n.sv
// demux_stream_1_to_n: 1-to-CHANNELS streaming demultiplexer.
// Each output channel owns a one-entry register with its own valid/ready
// handshake, so a stalled channel never blocks traffic to the others.
// Routing target is either the external sel (mode=0) or an internal
// round-robin pointer (mode=1).
// Optional feature macro: DEMUX_STREAM_ERR_EN -- adds a sticky sel_err
// output; an out-of-range sel in addressed mode is then accepted and
// dropped instead of stalling the input.
module demux_stream_1_to_n #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  localparam int SEL_W   = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mode,
  input  logic [SEL_W-1:0]          sel,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [SEL_W-1:0]          rr_ptr
`ifdef DEMUX_STREAM_ERR_EN
  ,
  output logic                      sel_err
`endif
);

  // Number of codes the select/pointer field can express; may exceed CHANNELS.
  localparam int PTR_N = 1 << SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(CHANNELS - 1);

  logic [CHANNELS-1:0][WIDTH-1:0] out_data_r;
  logic [CHANNELS-1:0]            out_valid_r;
  logic [CHANNELS-1:0]            load_s;
  logic [CHANNELS-1:0]            drain_s;
  logic [SEL_W-1:0]               rr_ptr_r;
  logic [SEL_W-1:0]               target_s;
  logic [PTR_N-1:0]               in_range_s;
  logic [PTR_N-1:0]               valid_pad_s;
  logic [PTR_N-1:0]               ready_pad_s;
  logic                           target_ok_s;
  logic                           slot_free_s;
  logic                           in_ready_s;
  logic                           accept_s;
`ifdef DEMUX_STREAM_ERR_EN
  logic                           drop_s;
  logic                           sel_err_r;
`endif

  // Constant mask of select codes that map onto a real channel.
  always_comb begin
    in_range_s = {PTR_N{1'b0}};
    for (int i = 0; i < PTR_N; i++) begin
      if (i < CHANNELS) begin
        in_range_s[i] = 1'b1;
      end else begin
        in_range_s[i] = 1'b0;
      end
    end
  end

  // Target selection and input handshake; status vectors are zero-padded so
  // an out-of-range target indexes a defined bit.
  always_comb begin
    target_s    = mode ? rr_ptr_r : sel;
    valid_pad_s = PTR_N'(out_valid_r);
    ready_pad_s = PTR_N'(out_ready);
    target_ok_s = in_range_s[target_s];
    slot_free_s = !valid_pad_s[target_s] || ready_pad_s[target_s];
`ifdef DEMUX_STREAM_ERR_EN
    drop_s      = !mode && !target_ok_s;
    in_ready_s  = (target_ok_s && slot_free_s) || drop_s;
`else
    in_ready_s  = target_ok_s && slot_free_s;
`endif
    accept_s    = in_valid && in_ready_s;
  end

  // Per-channel load and drain strobes.
  always_comb begin
    load_s  = {CHANNELS{1'b0}};
    drain_s = {CHANNELS{1'b0}};
    for (int k = 0; k < CHANNELS; k++) begin
      load_s[k]  = accept_s && target_ok_s && (target_s == SEL_W'(k));
      drain_s[k] = out_valid_r[k] && out_ready[k];
    end
  end

  // Channel output registers: a load wins over a drain, so a full channel
  // sustains one transfer per cycle; a drained channel keeps its last data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_r  <= {(CHANNELS*WIDTH){1'b0}};
      out_valid_r <= {CHANNELS{1'b0}};
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (load_s[k]) begin
          out_data_r[k]  <= in_data;
          out_valid_r[k] <= 1'b1;
        end else if (drain_s[k]) begin
          out_valid_r[k] <= 1'b0;
        end
      end
    end
  end

  // Round-robin pointer: steps only on a round-robin accept and wraps at the
  // last real channel, so it never holds an out-of-range code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_r <= {SEL_W{1'b0}};
    end else if (accept_s && mode) begin
      if (rr_ptr_r == LAST_CH) begin
        rr_ptr_r <= {SEL_W{1'b0}};
      end else begin
        rr_ptr_r <= rr_ptr_r + SEL_W'(1);
      end
    end
  end

`ifdef DEMUX_STREAM_ERR_EN
  // Sticky flag recording that an addressed beat was dropped; cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_err_r <= 1'b0;
    end else if (accept_s && drop_s) begin
      sel_err_r <= 1'b1;
    end
  end

  assign sel_err = sel_err_r;
`endif

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_valid = out_valid_r;
  assign rr_ptr    = rr_ptr_r;

endmodule

// File: doc/demux_stream_1_to_n.md
Name: demux_stream_1_to_n

Overview:
Parametrised 1-to-N streaming demultiplexer with registered outputs and valid/ready handshakes on the input and on every output channel. Each channel has a one-entry output register, so a stalled channel does not block traffic to other channels. The block supports addressed routing (external select) and round-robin routing (internal pointer). It is the clocked, generalised successor to the combinational 1-to-4 demux in the Digital Electronics experiments.

Parameters:
WIDTH, 8, data width in bits (>=1)
CHANNELS, 4, number of output channels (2..16)
Derived localparam SEL_W = $clog2(CHANNELS), width of select and pointer

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous reset, active-high
mode  input  1  0 = addressed (use sel), 1 = round-robin (use rr_ptr)
sel  input  SEL_W  target channel in addressed mode
in_data  input  WIDTH  input payload
in_valid  input  1  input payload valid
in_ready  output  1  block can accept in_data this cycle
out_data  output  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
out_valid  output  CHANNELS  per-channel data valid
out_ready  input  CHANNELS  per-channel downstream ready
rr_ptr  output  SEL_W  current round-robin target

Behaviour:
- Reset (async, rst=1): out_valid=0, out_data=0, rr_ptr=0. Held data is discarded. in_ready follows the combinational rule below; with all registers empty it is 1 for any in-range target.
- Target t = mode ? rr_ptr : sel. This is combinational, so a mode change takes effect in the same cycle.
- in_ready = (t < CHANNELS) && (!out_valid[t] || out_ready[t]). in_ready is combinational and does not depend on in_valid.
- Accept occurs when in_valid && in_ready. On the next edge: out_data[t] <= in_data, out_valid[t] <= 1. Latency is 1 cycle from accept to out_valid.
- Drain on channel k occurs when out_valid[k] && out_ready[k]. If channel k is not loaded in the same cycle, out_valid[k] <= 0 and out_data[k] holds its last value.
- Simultaneous drain and load on the same channel: the new data is loaded and out_valid stays 1. Full throughput is 1 transfer/cycle per channel.
- Channels are independent. A drain on channel j while loading channel k (j != k) occurs in the same cycle.
- out_valid[k] and out_data[k] stay stable while out_valid[k]=1 and out_ready[k]=0.
- rr_ptr advances by 1 only on an accept while mode=1. It wraps from CHANNELS-1 to 0. It holds in mode=0 and holds while stalled. Switching mode does not reset it.
- Out-of-range target (t >= CHANNELS, possible only when CHANNELS is not a power of 2): in_ready=0, no accept, no state change. rr_ptr can never reach an out-of-range value.
- in_valid=0: no accept, even if in_ready=1.

Optional Feature:
Macro DEMUX_STREAM_ERR_EN.
- Defined: adds output port sel_err (1 bit, reset 0). An out-of-range sel in addressed mode gives in_ready=1, and the beat is accepted and dropped (no channel written). sel_err is set on the next edge and stays set until rst.
- Undefined: no sel_err port. Out-of-range sel stalls as described in Behaviour.

Test Plan:
- Reset/idle: assert rst mid-run with out_valid=4'b0101 -> out_valid=0, out_data=0, rr_ptr=0 immediately (async), before the next clk edge.
- Addressed routing: mode=0, out_ready=4'hF, send 0xA1/sel=2 then 0xB2/sel=0 -> out_valid[2]=1 with data 0xA1 one cycle after the first accept, then out_valid[0]=1 with 0xB2; other channels stay 0.
- Backpressure isolation: out_ready[1]=0, load 0x11 to ch1, then present 0x22 to ch1 -> in_ready=0 and ch1 holds 0x11. Present 0x33 to ch3 -> accepted, out_data[3]=0x33.
- Simultaneous drain+load: ch0 holds 0x44 with out_ready[0]=1; accept 0x55 to ch0 in the same cycle -> out_valid[0] stays 1 and data becomes 0x55 next cycle.
- Round-robin wrap: mode=1, all ready, send 6 beats 0..5 -> they land on ch0,1,2,3,0,1 and rr_ptr reads 2 afterwards. Stall ch2 -> rr_ptr holds at 2 and in_ready=0.
- CHANNELS=3 with sel=3 -> without DEMUX_STREAM_ERR_EN: in_ready=0 and no output changes. With the macro defined: beat dropped, sel_err=1 and stays 1 until rst.
